// File: rtl/dmem_port_arbiter.sv
// Core/DMA arbiter for the byte-enabled data memory: fixed core priority with a DMA starvation guard.
// Define DMEM_ARB_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of forcing alignment.
module dmem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned MAXWAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [1:0]    c_size,
  input  logic [AW-1:0] c_addr,
  input  logic [31:0]   c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [31:0]   c_rdata,
  output logic          c_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          m_en,
  output logic [3:0]    m_we,
  output logic [AW-3:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] MAXW = CW'(MAXWAIT);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          rv_c_q, rv_c_d, rv_d_q, rv_d_d;
  logic [1:0]    size_q, size_d;
  logic [1:0]    off_q, off_d;
  logic          err_c_q, err_c_d, err_d_q, err_d_d;

  logic          g_any, g_we, mis, rd;
  logic [1:0]    g_size;
  logic [AW-1:0] g_addr;
  logic [31:0]   g_wdata;
  logic [3:0]    be;
  logic [31:0]   lane;

  // Core wins conflicts until the DMA port has been blocked MAXWAIT times in a row
  always_comb begin
    d_gnt = d_req & (~c_req | (wait_cnt_q == MAXW));
    c_gnt = c_req & ~d_gnt;
    g_any = c_gnt | d_gnt;
  end

  always_comb begin
    g_we    = d_gnt ? d_we    : c_we;
    g_size  = d_gnt ? d_size  : c_size;
    g_addr  = d_gnt ? d_addr  : c_addr;
    g_wdata = d_gnt ? d_wdata : c_wdata;
  end

  always_comb begin
    mis = 1'b0;
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    if (g_size == 2'b01) mis = g_any & g_addr[0];
    else if (g_size != 2'b00) mis = g_any & (|g_addr[1:0]);
`endif
  end

  // Lane enables and replicated store data; sub-size address bits are ignored for half/word
  always_comb begin
    m_en    = 1'b0;
    m_we    = 4'b0000;
    m_addr  = '0;
    m_wdata = '0;
    be      = 4'b0000;
    if (g_any) begin
      m_en   = ~mis;
      m_addr = g_addr[AW-1:2];
      case (g_size)
        2'b00: begin
          m_wdata = {4{g_wdata[7:0]}};
          be      = 4'b0001 << g_addr[1:0];
        end
        2'b01: begin
          m_wdata = {2{g_wdata[15:0]}};
          be      = g_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          m_wdata = g_wdata;
          be      = 4'b1111;
        end
      endcase
      m_we = (g_we & ~mis) ? be : 4'b0000;
    end
  end

  always_comb begin
    rd      = g_any & ~g_we & ~mis;
    rv_c_d  = rd & c_gnt;
    rv_d_d  = rd & d_gnt;
    size_d  = rd ? g_size : size_q;
    off_d   = rd ? g_addr[1:0] : off_q;
    err_c_d = c_gnt & mis;
    err_d_d = d_gnt & mis;
    wait_cnt_d = wait_cnt_q;
    if (d_gnt) wait_cnt_d = '0;
    else if (d_req && (wait_cnt_q != MAXW)) wait_cnt_d = wait_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      rv_c_q     <= 1'b0;
      rv_d_q     <= 1'b0;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      err_c_q    <= 1'b0;
      err_d_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rv_c_q     <= rv_c_d;
      rv_d_q     <= rv_d_d;
      size_q     <= size_d;
      off_q      <= off_d;
      err_c_q    <= err_c_d;
      err_d_q    <= err_d_d;
    end
  end

  // Right-justify the returning lane; the owner alone sees data
  always_comb begin
    case (size_q)
      2'b00:   lane = {24'h0, m_rdata[{off_q, 3'b000} +: 8]};
      2'b01:   lane = {16'h0, (off_q[1] ? m_rdata[31:16] : m_rdata[15:0])};
      default: lane = m_rdata;
    endcase
    c_rdata = rv_c_q ? lane : 32'h0;
    d_rdata = rv_d_q ? lane : 32'h0;
  end

  assign c_rvalid = rv_c_q;
  assign d_rvalid = rv_d_q;
  assign c_err    = err_c_q;
  assign d_err    = err_d_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized bench for dmem_port_arbiter against a byte-array memory model and arbitration rules.
module tb_dmem_port_arbiter;
  localparam int AW      = 32;
  localparam int MAXWAIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, d_req, d_we;
  logic [1:0]    c_size, d_size;
  logic [AW-1:0] c_addr, d_addr;
  logic [31:0]   c_wdata, d_wdata;
  logic          c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [31:0]   c_rdata, d_rdata;
  logic          m_en;
  logic [3:0]    m_we;
  logic [AW-3:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata = 32'h0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.AW(AW), .MAXWAIT(MAXWAIT)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Environment memory the DUT drives (32 words)
  logic [31:0] ram [32];
  always @(posedge clk) begin
    if (m_en) begin
      for (int i = 0; i < 4; i++)
        if (m_we[i]) ram[m_addr[4:0]][8*i +: 8] <= m_wdata[8*i +: 8];
      if (m_we == 4'b0000) m_rdata <= ram[m_addr[4:0]];
    end
  end

  // Reference model state
  logic [7:0]  mdl [128];
  int          cnt;
  bit          er_c, er_d, ee_c, ee_d;
  logic [31:0] er_data;
  bit          e_gc, e_gd, e_we, e_mis;
  int          e_nb, e_base;
  logic [31:0] e_wd;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_check();
    logic [31:0] a, rep;
    logic [1:0]  sz;
    logic [3:0]  we_m;
    int          ai;
    @(negedge clk);
    e_gd = d_req && (!c_req || cnt == MAXWAIT);
    e_gc = c_req && !e_gd;
    if (e_gd) begin e_we = d_we; sz = d_size; a = d_addr; e_wd = d_wdata; end
    else      begin e_we = c_we; sz = c_size; a = c_addr; e_wd = c_wdata; end
    e_nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ai     = int'(a[6:0]);
    e_base = ai - (ai % e_nb);
    e_mis  = 1'b0;
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    e_mis = (e_gc || e_gd) && ((ai % e_nb) != 0);
`endif
    we_m = 4'b0000;
    if ((e_gc || e_gd) && e_we && !e_mis)
      for (int k = 0; k < e_nb; k++) we_m[2'((e_base + k) % 4)] = 1'b1;
    rep = (e_nb == 1) ? {4{e_wd[7:0]}} : (e_nb == 2) ? {2{e_wd[15:0]}} : e_wd;
    chk("c_gnt", 32'(c_gnt), 32'(e_gc));
    chk("d_gnt", 32'(d_gnt), 32'(e_gd));
    chk("m_en", 32'(m_en), 32'((e_gc || e_gd) && !e_mis));
    chk("m_we", 32'(m_we), 32'(we_m));
    if (!(e_gc || e_gd)) begin
      chk("m_addr_idle", 32'(m_addr), 32'h0);
      chk("m_wdata_idle", m_wdata, 32'h0);
    end else if (!e_mis) begin
      chk("m_addr", 32'(m_addr), 32'(a[31:2]));
      chk("m_wdata", m_wdata, rep);
    end
    chk("c_rvalid", 32'(c_rvalid), 32'(er_c));
    chk("d_rvalid", 32'(d_rvalid), 32'(er_d));
    chk("c_rdata", c_rdata, er_c ? er_data : 32'h0);
    chk("d_rdata", d_rdata, er_d ? er_data : 32'h0);
    chk("c_err", 32'(c_err), 32'(ee_c));
    chk("d_err", 32'(d_err), 32'(ee_d));
  endtask

  task automatic model_advance();
    logic [31:0] v;
    bit          rdx;
    rdx = (e_gc || e_gd) && !e_we && !e_mis;
    v = 32'h0;
    if (rdx) for (int k = 0; k < e_nb; k++) v = v | (32'(mdl[(e_base + k) % 128]) << (8 * k));
    er_c = rdx && e_gc;
    er_d = rdx && e_gd;
    er_data = v;
    ee_c = e_gc && e_mis;
    ee_d = e_gd && e_mis;
    if ((e_gc || e_gd) && e_we && !e_mis)
      for (int k = 0; k < e_nb; k++) mdl[(e_base + k) % 128] = e_wd[8*k +: 8];
    if (e_gd) cnt = 0;
    else if (d_req && cnt < MAXWAIT) cnt = cnt + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_c(input logic req, input logic we, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd);
    c_req = req; c_we = we; c_size = sz; c_addr = addr; c_wdata = wd;
  endtask

  task automatic set_d(input logic req, input logic we, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd);
    d_req = req; d_we = we; d_size = sz; d_addr = addr; d_wdata = wd;
  endtask

  task automatic model_reset();
    er_c = 1'b0; er_d = 1'b0; ee_c = 1'b0; ee_d = 1'b0; er_data = 32'h0; cnt = 0;
  endtask

  initial begin
    for (int w = 0; w < 32; w++) begin
      ram[w] = (w == 21) ? 32'hFFFF0000 : $urandom;
      for (int k = 0; k < 4; k++) mdl[4*w + k] = ram[w][8*k +: 8];
    end
    model_reset();
    reset = 1'b0;
    set_c(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    @(negedge clk);
    chk("reset_c_rvalid", 32'(c_rvalid), 32'h0);
    chk("reset_d_rdata", d_rdata, 32'h0);
    chk("reset_c_err", 32'(c_err), 32'h0);
    chk("reset_m_en", 32'(m_en), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // sb 0x55
    set_c(1'b1, 1'b1, 2'd0, 32'h55, 32'h000000AB);
    model_check();
    chk("sb_gnt", 32'(c_gnt), 32'h1);
    chk("sb_m_addr", 32'(m_addr), 32'h15);
    chk("sb_m_we", 32'(m_we), 32'h2);
    chk("sb_m_wdata", m_wdata, 32'hABABABAB);
    model_advance();
    // lh 0x56
    set_c(1'b1, 1'b0, 2'd1, 32'h56, 32'h0);
    model_check();
    model_advance();
    // DMA sw 0x54 during the lh return
    set_c(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    set_d(1'b1, 1'b1, 2'd2, 32'h54, 32'h12345678);
    model_check();
    chk("lh_rvalid", 32'(c_rvalid), 32'h1);
    chk("lh_rdata", c_rdata, 32'h0000FFFF);
    chk("lh_d_rvalid", 32'(d_rvalid), 32'h0);
    model_advance();
    // core lw 0x54
    set_d(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    set_c(1'b1, 1'b0, 2'd2, 32'h54, 32'h0);
    model_check();
    model_advance();
    set_c(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    model_check();
    chk("lw_rdata", c_rdata, 32'h12345678);
    model_advance();

    // Continuous contention: 4 core grants then 1 DMA grant
    set_c(1'b1, 1'b1, 2'd2, 32'h10, 32'hC0DE0001);
    set_d(1'b1, 1'b1, 2'd2, 32'h20, 32'hD0DE0002);
    for (int i = 0; i < 10; i++) begin
      model_check();
      chk("arb_d_gnt", 32'(d_gnt), 32'(i % 5 == 4));
      chk("arb_c_gnt", 32'(c_gnt), 32'(i % 5 != 4));
      model_advance();
    end

    // Reset during a read return
    set_d(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    set_c(1'b1, 1'b0, 2'd2, 32'h54, 32'h0);
    model_check();
    model_advance();
    set_c(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_rvalid_drop", 32'(c_rvalid), 32'h0);
    chk("rst_rdata_drop", c_rdata, 32'h0);
    model_reset();
    model_check();
    model_advance();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      model_check();
      chk("post_rst_rvalid", 32'(c_rvalid), 32'h0);
      model_advance();
    end

    // Misaligned sw 0x56
    set_c(1'b1, 1'b1, 2'd2, 32'h56, 32'hDEADBEEF);
    model_check();
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    chk("mis_m_en", 32'(m_en), 32'h0);
    model_advance();
    set_c(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    model_check();
    chk("mis_err", 32'(c_err), 32'h1);
    model_advance();
    model_check();
    chk("mis_err_clear", 32'(c_err), 32'h0);
`else
    chk("mis_m_addr", 32'(m_addr), 32'h15);
    chk("mis_m_we", 32'(m_we), 32'hF);
    model_advance();
    set_c(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    model_check();
    chk("mis_no_err", 32'(c_err), 32'h0);
`endif
    model_advance();

    // Random traffic; a blocked requester holds its request
    for (int n = 0; n < 3000; n++) begin
      if (!(c_req && !e_gc))
        set_c(($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              32'($urandom_range(0, 127)), $urandom);
      if (!(d_req && !e_gd))
        set_d(($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              32'($urandom_range(0, 127)), $urandom);
      model_check();
      model_advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
